alarm_controller: RTL and testbench

- Downstream consumer of the minute/hour BCD counter chain in the alarm clock.
- Holds a programmable alarm time and compares it each cycle against the live BCD time.
- Runs the ring / snooze / stop state machine and drives the buzzer.
- Tick-based: all timing is counted in tick_1hz pulses; the block itself runs on the system clock.

---
 rtl/alarm_pkg.sv | 33 +++
 rtl/bcd_time_validator.sv | 17 +
 rtl/alarm_controller.sv | 173 +++++++++++++++++
 tb/tb_alarm_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm clock time path.
package alarm_pkg;

  localparam int MIN_ONES_W = 4;
  localparam int MIN_TENS_W = 3;
  localparam int HR_ONES_W  = 4;
  localparam int HR_TENS_W  = 2;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
  localparam logic [2:0] MIN_TENS_MAX  = 3'd5;
  localparam logic [5:0] HR_MAX        = 6'd23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_e;

  typedef struct packed {
    logic [HR_TENS_W-1:0]  hr_tens;
    logic [HR_ONES_W-1:0]  hr_ones;
    logic [MIN_TENS_W-1:0] min_tens;
    logic [MIN_ONES_W-1:0] min_ones;
  } bcd_time_t;

  // Binary hour value; wide enough for the largest encodable pair (3,15).
  function automatic logic [5:0] hours_bin(input logic [HR_TENS_W-1:0] tens,
                                           input logic [HR_ONES_W-1:0] ones);
    return 6'(tens) * 6'd10 + 6'(ones);
  endfunction

endpackage

// File: rtl/bcd_time_validator.sv
// Combinational range check of a BCD hh:mm value (00:00 .. 23:59).
module bcd_time_validator
  import alarm_pkg::*;
(
  input  logic [MIN_ONES_W-1:0] min_ones_i,
  input  logic [MIN_TENS_W-1:0] min_tens_i,
  input  logic [HR_ONES_W-1:0]  hr_ones_i,
  input  logic [HR_TENS_W-1:0]  hr_tens_i,
  output logic                  valid_o
);

  assign valid_o = (min_ones_i <= BCD_DIGIT_MAX) &&
                   (min_tens_i <= MIN_TENS_MAX) &&
                   (hr_ones_i  <= BCD_DIGIT_MAX) &&
                   (hours_bin(hr_tens_i, hr_ones_i) <= HR_MAX);

endmodule

// File: rtl/alarm_controller.sv
// Alarm time store, edge-detected time match and ring/snooze/stop sequencer.
//
// state   | meaning
// IDLE    | alarm disabled
// ARMED   | waiting for the live time to reach the alarm time
// RINGING | buzzer active, counting ring seconds
// SNOOZE  | buzzer paused, counting snooze seconds
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic                  signal,
  input  logic                  reset,
  input  logic                  tick_1hz,
  input  logic [MIN_ONES_W-1:0] cur_min_ones,
  input  logic [MIN_TENS_W-1:0] cur_min_tens,
  input  logic [HR_ONES_W-1:0]  cur_hr_ones,
  input  logic [HR_TENS_W-1:0]  cur_hr_tens,
  input  logic                  alarm_enable,
  input  logic                  alarm_set,
  input  logic [MIN_ONES_W-1:0] set_min_ones,
  input  logic [MIN_TENS_W-1:0] set_min_tens,
  input  logic [HR_ONES_W-1:0]  set_hr_ones,
  input  logic [HR_TENS_W-1:0]  set_hr_tens,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [MIN_ONES_W-1:0] alm_min_ones,
  output logic [MIN_TENS_W-1:0] alm_min_tens,
  output logic [HR_ONES_W-1:0]  alm_hr_ones,
  output logic [HR_TENS_W-1:0]  alm_hr_tens,
  output logic                  ring,
  output logic                  beep,
  output logic                  snoozing,
  output logic                  set_err
);

  localparam int RING_W = $clog2(RING_SEC);
  localparam int SNZ_W  = $clog2(SNOOZE_SEC);
  localparam int USED_W = $clog2(MAX_SNOOZE + 1);

  localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);
  localparam logic [SNZ_W-1:0]  SNZ_LAST  = SNZ_W'(SNOOZE_SEC - 1);
  localparam logic [USED_W-1:0] USED_MAX  = USED_W'(MAX_SNOOZE);

  bcd_time_t         cur_t, set_t, alm_q;
  logic              set_valid, eq, match_q, trigger;
  logic              ring_q, beep_q, snoozing_q, set_err_q;
  alarm_state_e      state_q;
  logic [RING_W-1:0] ring_cnt_q;
  logic [SNZ_W-1:0]  snz_cnt_q;
  logic [USED_W-1:0] used_q;

  assign cur_t = {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones};
  assign set_t = {set_hr_tens, set_hr_ones, set_min_tens, set_min_ones};

  bcd_time_validator u_set_check (
    .min_ones_i (set_min_ones),
    .min_tens_i (set_min_tens),
    .hr_ones_i  (set_hr_ones),
    .hr_tens_i  (set_hr_tens),
    .valid_o    (set_valid)
  );

  assign eq      = (cur_t == alm_q);
  assign trigger = eq & ~match_q;

  // Alarm time storage, match edge history and load-error pulse.
  always_ff @(posedge signal) begin
    if (reset) begin
      alm_q     <= '0;
      match_q   <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      set_err_q <= alarm_set & ~set_valid;
      if (alarm_set && set_valid) begin
        alm_q   <= set_t;
        // Loading the current minute must not ring until it comes round again.
        match_q <= 1'b1;
      end else begin
        match_q <= eq;
      end
    end
  end

  // Sequencer with registered ring/beep/snoozing outputs.
  always_ff @(posedge signal) begin
    if (reset || !alarm_enable) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      used_q     <= '0;
      ring_q     <= 1'b0;
      beep_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else if (alarm_set) begin
      // A rejected load leaves everything untouched, including this cycle's tick.
      if (set_valid) begin
        state_q    <= ARMED;
        ring_cnt_q <= '0;
        snz_cnt_q  <= '0;
        used_q     <= '0;
        ring_q     <= 1'b0;
        beep_q     <= 1'b0;
        snoozing_q <= 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: state_q <= ARMED;
        ARMED: begin
          if (trigger) begin
            state_q    <= RINGING;
            ring_cnt_q <= '0;
            ring_q     <= 1'b1;
            beep_q     <= 1'b0;
          end
        end
        RINGING: begin
          if (stop || (tick_1hz && ring_cnt_q == RING_LAST &&
                       !(snooze && used_q < USED_MAX))) begin
            state_q    <= ARMED;
            ring_cnt_q <= '0;
            used_q     <= '0;
            ring_q     <= 1'b0;
            beep_q     <= 1'b0;
          end else if (snooze && used_q < USED_MAX) begin
            state_q    <= SNOOZE;
            snz_cnt_q  <= '0;
            used_q     <= used_q + USED_W'(1);
            ring_q     <= 1'b0;
            beep_q     <= 1'b0;
            snoozing_q <= 1'b1;
          end else if (tick_1hz) begin
            ring_cnt_q <= ring_cnt_q + RING_W'(1);
            beep_q     <= ~beep_q;
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_q    <= ARMED;
            snz_cnt_q  <= '0;
            used_q     <= '0;
            snoozing_q <= 1'b0;
          end else if (tick_1hz) begin
            if (snz_cnt_q == SNZ_LAST) begin
              state_q    <= RINGING;
              ring_cnt_q <= '0;
              snz_cnt_q  <= '0;
              ring_q     <= 1'b1;
              beep_q     <= 1'b0;
              snoozing_q <= 1'b0;
            end else begin
              snz_cnt_q <= snz_cnt_q + SNZ_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alm_min_ones = alm_q.min_ones;
  assign alm_min_tens = alm_q.min_tens;
  assign alm_hr_ones  = alm_q.hr_ones;
  assign alm_hr_tens  = alm_q.hr_tens;
  assign ring         = ring_q;
  assign beep         = beep_q;
  assign snoozing     = snoozing_q;
  assign set_err      = set_err_q;

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: vector table plus corner sequences.
module tb_alarm_controller;

  logic       signal = 1'b0;
  logic       reset, tick_1hz, alarm_enable, alarm_set, snooze, stop;
  logic [3:0] cur_min_ones, cur_hr_ones, set_min_ones, set_hr_ones;
  logic [2:0] cur_min_tens, set_min_tens;
  logic [1:0] cur_hr_tens, set_hr_tens;
  logic [3:0] alm_min_ones, alm_hr_ones;
  logic [2:0] alm_min_tens;
  logic [1:0] alm_hr_tens;
  logic       ring, beep, snoozing, set_err;

  logic [12:0] cur_v, set_v, alm_e;
  logic [16:0] outs;

  assign {cur_hr_tens, cur_hr_ones, cur_min_tens, cur_min_ones} = cur_v;
  assign {set_hr_tens, set_hr_ones, set_min_tens, set_min_ones} = set_v;
  assign outs = {ring, snoozing, beep, set_err,
                 alm_hr_tens, alm_hr_ones, alm_min_tens, alm_min_ones};

  always #5 signal = ~signal;

  alarm_controller #(.RING_SEC(60), .SNOOZE_SEC(300), .MAX_SNOOZE(3)) dut (
    .signal(signal), .reset(reset), .tick_1hz(tick_1hz),
    .cur_min_ones(cur_min_ones), .cur_min_tens(cur_min_tens),
    .cur_hr_ones(cur_hr_ones), .cur_hr_tens(cur_hr_tens),
    .alarm_enable(alarm_enable), .alarm_set(alarm_set),
    .set_min_ones(set_min_ones), .set_min_tens(set_min_tens),
    .set_hr_ones(set_hr_ones), .set_hr_tens(set_hr_tens),
    .snooze(snooze), .stop(stop),
    .alm_min_ones(alm_min_ones), .alm_min_tens(alm_min_tens),
    .alm_hr_ones(alm_hr_ones), .alm_hr_tens(alm_hr_tens),
    .ring(ring), .beep(beep), .snoozing(snoozing), .set_err(set_err)
  );

  typedef struct packed {
    logic        rst, en, set, snz, stp, tck;
    logic [12:0] cur, setv;
    logic [16:0] exp;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [16:0] exp_q[$];

  function automatic logic [12:0] tm(input int ht, input int ho, input int mt, input int mo);
    return {2'(ht), 4'(ho), 3'(mt), 4'(mo)};
  endfunction

  function automatic logic [16:0] o(input logic r, input logic s, input logic b,
                                    input logic e, input logic [12:0] a);
    return {r, s, b, e, a};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic en, input logic set,
                               input logic snz, input logic stp, input logic tck,
                               input logic [12:0] cur, input logic [12:0] setv,
                               input logic [16:0] exp);
    vec_t v;
    v.rst = rst; v.en = en; v.set = set; v.snz = snz; v.stp = stp; v.tck = tck;
    v.cur = cur; v.setv = setv; v.exp = exp;
    return v;
  endfunction

  // Expected result is queued as the stimulus goes in, popped once the DUT has clocked.
  task automatic step(input string nm, input logic [16:0] e);
    logic [16:0] ee;
    exp_q.push_back(e);
    @(posedge signal);
    #1;
    ee = exp_q.pop_front();
    total++;
    if (outs !== ee) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, outs, ee);
    end
    reset = 0; alarm_set = 0; snooze = 0; stop = 0; tick_1hz = 0;
  endtask

  // Expected outputs with the currently stored alarm time.
  function automatic logic [16:0] ex(input logic r, input logic s, input logic b);
    return o(r, s, b, 1'b0, alm_e);
  endfunction

  vec_t tbl[14];
  logic [12:0] T0000, T1200, T0729, T0730, T0731, T2400, T1260, T1015, T1016;
  int   toggles;
  logic prev_beep;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    T0000 = tm(0,0,0,0); T1200 = tm(1,2,0,0); T0729 = tm(0,7,2,9);
    T0730 = tm(0,7,3,0); T0731 = tm(0,7,3,1); T2400 = tm(2,4,0,0);
    T1260 = tm(1,2,6,0); T1015 = tm(1,0,1,5); T1016 = tm(1,0,1,6);

    //              rst en set snz stp tck cur    setv   expected {ring,snz,beep,err,alm}
    tbl[0]  = mkv(1, 1, 0, 0, 0, 0, T1200, T0000, o(0,0,0,0,T0000));
    tbl[1]  = mkv(1, 1, 0, 0, 0, 0, T1200, T0000, o(0,0,0,0,T0000));
    tbl[2]  = mkv(0, 1, 0, 0, 0, 0, T1200, T0000, o(0,0,0,0,T0000));
    tbl[3]  = mkv(0, 1, 1, 0, 0, 0, T1200, T0730, o(0,0,0,0,T0730));
    tbl[4]  = mkv(0, 1, 0, 0, 0, 0, T0729, T0000, o(0,0,0,0,T0730));
    tbl[5]  = mkv(0, 1, 0, 0, 0, 0, T0730, T0000, o(1,0,0,0,T0730));
    tbl[6]  = mkv(0, 1, 0, 0, 0, 0, T0730, T0000, o(1,0,0,0,T0730));
    tbl[7]  = mkv(0, 1, 0, 0, 0, 1, T0730, T0000, o(1,0,1,0,T0730));
    tbl[8]  = mkv(0, 1, 1, 0, 0, 0, T0730, T2400, o(1,0,1,1,T0730));
    tbl[9]  = mkv(0, 1, 0, 0, 0, 0, T0730, T0000, o(1,0,1,0,T0730));
    tbl[10] = mkv(0, 1, 1, 0, 0, 0, T0730, T1260, o(1,0,1,1,T0730));
    tbl[11] = mkv(0, 1, 0, 0, 1, 0, T0730, T0000, o(0,0,0,0,T0730));
    tbl[12] = mkv(0, 1, 0, 0, 0, 0, T0730, T0000, o(0,0,0,0,T0730));
    tbl[13] = mkv(0, 0, 0, 0, 0, 0, T0730, T0000, o(0,0,0,0,T0730));

    reset = 0; alarm_set = 0; snooze = 0; stop = 0; tick_1hz = 0;
    alarm_enable = 0; cur_v = T1200; set_v = T0000;

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst; alarm_enable = tbl[i].en; alarm_set = tbl[i].set;
      snooze = tbl[i].snz; stop = tbl[i].stp; tick_1hz = tbl[i].tck;
      cur_v = tbl[i].cur; set_v = tbl[i].setv;
      step($sformatf("table%0d", i), tbl[i].exp);
    end
    alm_e = T0730;

    // Ring timeout: 60 ticks, beep alternates, silence on the 60th, no retrigger.
    alarm_enable = 1; cur_v = T0731;
    step("rearm", ex(0,0,0));
    cur_v = T0730;
    step("trig_timeout", ex(1,0,0));
    toggles = 0; prev_beep = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      tick_1hz = 1;
      step($sformatf("ring_tick%0d", i), (i < 60) ? ex(1,0,1'(i % 2)) : ex(0,0,0));
      if (beep !== prev_beep) toggles++;
      prev_beep = beep;
      step($sformatf("ring_gap%0d", i), (i < 60) ? ex(1,0,1'(i % 2)) : ex(0,0,0));
    end
    total++;
    if (toggles != 60) begin
      bad++;
      $display("FAIL beep_toggles: got %0d want 60", toggles);
    end
    for (int i = 0; i < 10; i++) begin
      tick_1hz = 1;
      step("no_retrigger", ex(0,0,0));
    end

    // Three full snoozes, fourth ignored.
    cur_v = T0731; step("snz_rearm", ex(0,0,0));
    cur_v = T0730; step("snz_trig", ex(1,0,0));
    for (int k = 1; k <= 3; k++) begin
      snooze = 1;
      step($sformatf("snooze%0d", k), ex(0,1,0));
      for (int t = 1; t <= 300; t++) begin
        tick_1hz = 1;
        step($sformatf("snz%0d_tick%0d", k, t), (t < 300) ? ex(0,1,0) : ex(1,0,0));
      end
    end
    snooze = 1;           step("snooze4_ignored", ex(1,0,0));
    tick_1hz = 1;         step("ring_after_ignored", ex(1,0,1));
    snooze = 1; stop = 1; step("stop_after_max", ex(0,0,0));

    // snooze+stop together: stop wins.
    cur_v = T0731; step("rearm2", ex(0,0,0));
    cur_v = T0730; step("trig2", ex(1,0,0));
    snooze = 1; stop = 1; step("stop_beats_snooze", ex(0,0,0));

    // snooze on the timeout tick: snooze wins.
    cur_v = T0731; step("rearm3", ex(0,0,0));
    cur_v = T0730; step("trig3", ex(1,0,0));
    for (int i = 1; i <= 59; i++) begin
      tick_1hz = 1;
      step($sformatf("pre_timeout%0d", i), ex(1,0,1'(i % 2)));
    end
    tick_1hz = 1; snooze = 1; step("snooze_beats_timeout", ex(0,1,0));
    stop = 1;                 step("stop_in_snooze", ex(0,0,0));

    // Loading the current minute does not ring until it recurs.
    cur_v = T1015; set_v = T1015; alarm_set = 1; alm_e = T1015;
    step("load_now", ex(0,0,0));
    for (int i = 0; i < 3; i++) step("load_now_quiet", ex(0,0,0));
    cur_v = T1016; step("minute_past", ex(0,0,0));
    cur_v = T1015; step("minute_again", ex(1,0,0));

    // Disable from SNOOZE, then reset while ringing.
    snooze = 1; step("snz_before_dis", ex(0,1,0));
    for (int i = 0; i < 3; i++) begin
      tick_1hz = 1;
      step("snz_hold", ex(0,1,0));
    end
    alarm_enable = 0; step("disable_in_snooze", ex(0,0,0));
    alarm_enable = 1; step("reenable", ex(0,0,0));
    cur_v = T1016;    step("rearm4", ex(0,0,0));
    cur_v = T1015;    step("trig4", ex(1,0,0));
    tick_1hz = 1;     step("beep4", ex(1,0,1));
    reset = 1; alm_e = T0000;
    step("reset_while_ringing", ex(0,0,0));
    step("after_reset", ex(0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
